// File: rtl/product_reg_seq_pkg.sv
// Shared definitions for the product/accumulator register-bank tile sequencer.
package product_reg_seq_pkg;

  localparam int PRS_ROWS = 32;

  localparam int PRS_K_W = 8;

  // Must track the multiplier pipeline depth so wr_en lines up with products.
  localparam int PRS_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    FLUSH,
    DRAIN
  } seq_state_t;

endpackage

// File: rtl/product_reg_seq_if.sv
// Control, input-beat, bank-enable and drain handshake signals of the tile sequencer.
interface product_reg_seq_if #(
    parameter int ROWS = 32,
    parameter int K_W  = 8
);
    localparam int ROW_W = $clog2(ROWS);

    logic             start;
    logic [K_W-1:0]   k_len;
    logic [ROWS-1:0]  row_mask;
    logic             busy;
    logic             done;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [ROWS-1:0]  wr_en;
    logic             drain_valid;
    logic             drain_ready;
    logic [ROW_W-1:0] drain_row;
    logic             drain_last;

    // master: the sequencer itself; slave: controller, front-end and write-back side.
    modport master (
        input  start, k_len, row_mask, in_valid, drain_ready,
        output busy, done, clr, in_ready, wr_en, drain_valid, drain_row, drain_last
    );

    modport slave (
        output start, k_len, row_mask, in_valid, drain_ready,
        input  busy, done, clr, in_ready, wr_en, drain_valid, drain_row, drain_last
    );

endinterface

// File: rtl/product_reg_seq_row_prio_enc.sv
// Lowest-set-bit index of a row vector, plus a flag telling whether any higher bit is also set.
module row_prio_enc #(
    parameter int ROWS = 32
) (
    input  logic [ROWS-1:0]          vec_i,
    output logic [$clog2(ROWS)-1:0]  idx_o,
    output logic                     more_o
);
    localparam int ROW_W = $clog2(ROWS);

    always_comb begin
        idx_o = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = ROW_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if more rows remain.
    assign more_o = |(vec_i & (vec_i - ROWS'(1)));

endmodule

// File: rtl/product_reg_seq.sv
// Tile sequencer: clears the product bank, accepts k_len beats, issues per-row write
// enables at multiplier latency, then drains the masked rows over valid/ready.
module product_reg_seq
    import product_reg_seq_pkg::*;
#(
    parameter int ROWS = PRS_ROWS,
    parameter int K_W  = PRS_K_W,
    parameter int LAT  = PRS_LAT
) (
    input  logic                clk,
    input  logic                rst_n,
    product_reg_seq_if.master   bus
);
    localparam int ROW_W = $clog2(ROWS);

    seq_state_t       state_q, state_d;
    logic [K_W-1:0]   k_len_q, k_len_d;
    logic [K_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [ROWS-1:0]  mask_q, mask_d;
    logic [ROWS-1:0]  rem_q, rem_d;
    logic [LAT-1:0]   pipe_q, pipe_d;
    logic             done_q, done_d;

    logic             accept;
    logic             xfer;
    logic [ROW_W-1:0] enc_idx;
    logic             enc_more;

    assign accept = (state_q == ACCUM) && bus.in_valid;
    assign xfer   = (state_q == DRAIN) && bus.drain_ready;

    // rem_q holds the rows not yet drained; its lowest set bit is the current row.
    row_prio_enc #(.ROWS(ROWS)) u_enc (
        .vec_i  (rem_q),
        .idx_o  (enc_idx),
        .more_o (enc_more)
    );

    generate
        if (LAT == 1) begin : g_pipe1
            assign pipe_d = accept;
        end else begin : g_pipen
            assign pipe_d = {pipe_q[LAT-2:0], accept};
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        k_len_d    = k_len_q;
        beat_cnt_d = beat_cnt_q;
        mask_d     = mask_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    k_len_d    = bus.k_len;
                    mask_d     = bus.row_mask;
                    rem_d      = bus.row_mask;
                    beat_cnt_d = '0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                if (k_len_q != '0) begin
                    state_d = ACCUM;
                end else if (mask_q != '0) begin
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (beat_cnt_q == k_len_q - K_W'(1)) begin
                        state_d = FLUSH;
                    end else begin
                        beat_cnt_d = beat_cnt_q + K_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (pipe_q == '0) begin
                    if (mask_q != '0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (xfer) begin
                    rem_d = rem_q & (rem_q - ROWS'(1));
                    if (!enc_more) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_len_q    <= '0;
            beat_cnt_q <= '0;
            mask_q     <= '0;
            rem_q      <= '0;
            pipe_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_len_q    <= k_len_d;
            beat_cnt_q <= beat_cnt_d;
            mask_q     <= mask_d;
            rem_q      <= rem_d;
            pipe_q     <= pipe_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.clr         = (state_q == CLEAR);
    assign bus.in_ready    = (state_q == ACCUM);
    assign bus.wr_en       = pipe_q[LAT-1] ? mask_q : '0;
    assign bus.drain_valid = (state_q == DRAIN);
    assign bus.drain_row   = (state_q == DRAIN) ? enc_idx : '0;
    assign bus.drain_last  = (state_q == DRAIN) && !enc_more;

endmodule

// File: tb/tb_product_reg_seq.sv
// Directed bench for product_reg_seq with hand-derived cycle positions (LAT=2, ROWS=32).
module tb_product_reg_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    product_reg_seq_if #(.ROWS(32), .K_W(8)) bus ();

    product_reg_seq #(.ROWS(32), .K_W(8), .LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    int acc_w[$];
    int wr_w[$];
    int rows[$];
    int clr_w, done_w, rdy_off_w, dv_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check_idle_outputs(input string nm);
        check_eq({nm, "_busy"}, bus.busy, 0);
        check_eq({nm, "_done"}, bus.done, 0);
        check_eq({nm, "_clr"}, bus.clr, 0);
        check_eq({nm, "_in_ready"}, bus.in_ready, 0);
        check_eq({nm, "_wr_en"}, bus.wr_en, 0);
        check_eq({nm, "_drain_valid"}, bus.drain_valid, 0);
        check_eq({nm, "_drain_row"}, bus.drain_row, 0);
        check_eq({nm, "_drain_last"}, bus.drain_last, 0);
    endtask

    // Window 0 is the cycle start is driven; each later window is observed 1 time unit after its edge.
    task automatic run_tile(input string nm, input logic [7:0] k, input logic [31:0] m,
                            input logic [31:0] iv_pat, input int stall, input int start2_w,
                            input int exp_last);
        int  prev_row;
        logic prev_stall;
        logic prev_rdy;
        int  scnt;
        acc_w.delete(); wr_w.delete(); rows.delete();
        clr_w = -1; done_w = -1; rdy_off_w = -1; dv_cnt = 0;
        prev_row = 0; prev_stall = 1'b0; prev_rdy = 1'b0; scnt = 0;
        bus.start = 1'b1; bus.k_len = k; bus.row_mask = m;
        bus.in_valid = iv_pat[0]; bus.drain_ready = 1'b0;
        for (int w = 1; w < 200; w++) begin
            step();
            bus.start = (w == start2_w);
            if (w == start2_w) begin
                bus.k_len = 8'd7;
                bus.row_mask = 32'h1;
            end
            bus.in_valid = (w < 32) ? iv_pat[w] : 1'b0;
            bus.drain_ready = (scnt >= stall);
            if (w == 1) check_eq({nm, "_busy_w1"}, bus.busy, 1);
            if (bus.clr) clr_w = w;
            if (bus.in_ready && bus.in_valid) acc_w.push_back(w);
            if (prev_rdy && !bus.in_ready && rdy_off_w < 0) rdy_off_w = w;
            prev_rdy = bus.in_ready;
            if (bus.wr_en != '0) begin
                wr_w.push_back(w);
                check_eq({nm, "_wr_val"}, bus.wr_en, m);
            end
            if (prev_stall) begin
                check_eq({nm, "_hold_valid"}, bus.drain_valid, 1);
                check_eq({nm, "_hold_row"}, bus.drain_row, prev_row);
            end
            if (bus.drain_valid) begin
                dv_cnt++;
                check_eq({nm, "_last"}, bus.drain_last, (int'(bus.drain_row) == exp_last));
                if (bus.drain_ready) begin
                    rows.push_back(int'(bus.drain_row));
                    scnt = 0;
                    prev_stall = 1'b0;
                end else begin
                    scnt++;
                    prev_stall = 1'b1;
                    prev_row = int'(bus.drain_row);
                end
            end else begin
                prev_stall = 1'b0;
            end
            if (bus.done) begin
                done_w = w;
                check_eq({nm, "_busy_at_done"}, bus.busy, 0);
                break;
            end
        end
        if (done_w < 0) check_eq({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.k_len = '0; bus.row_mask = '0;
        bus.in_valid = 1'b0; bus.drain_ready = 1'b0;
        step();
        step();
        check_idle_outputs("rst");
        rst_n = 1'b1;
        step();

        // Basic tile: full mask, continuous input, no backpressure.
        run_tile("t1", 8'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 31);
        check_eq("t1_clr_w", clr_w, 1);
        check_eq("t1_acc_n", acc_w.size(), 3);
        check_eq("t1_acc0", qat(acc_w, 0), 2);
        check_eq("t1_acc2", qat(acc_w, 2), 4);
        check_eq("t1_rdy_off", rdy_off_w, 5);
        check_eq("t1_wr_n", wr_w.size(), 3);
        check_eq("t1_wr0", qat(wr_w, 0), 4);
        check_eq("t1_wr2", qat(wr_w, 2), 6);
        check_eq("t1_rows_n", rows.size(), 32);
        for (int i = 0; i < 32; i++) check_eq("t1_row", qat(rows, i), i);
        check_eq("t1_done_w", done_w, 40);

        // Throttled input, started in the done cycle of the previous tile.
        run_tile("t2", 8'd3, 32'hFFFF_FFFF, 32'h0000_0066, 0, -1, 31);
        check_eq("t2_acc_n", acc_w.size(), 3);
        check_eq("t2_acc0", qat(acc_w, 0), 2);
        check_eq("t2_acc1", qat(acc_w, 1), 5);
        check_eq("t2_acc2", qat(acc_w, 2), 6);
        check_eq("t2_wr0", qat(wr_w, 0), 4);
        check_eq("t2_wr1", qat(wr_w, 1), 7);
        check_eq("t2_wr2", qat(wr_w, 2), 8);
        check_eq("t2_wr_n", wr_w.size(), 3);
        check_eq("t2_rdy_off", rdy_off_w, 7);
        check_eq("t2_done_w", done_w, 42);

        // Sparse mask with two stall cycles per row.
        run_tile("t3", 8'd1, 32'h8000_0011, 32'hFFFF_FFFF, 2, -1, 31);
        check_eq("t3_wr_n", wr_w.size(), 1);
        check_eq("t3_wr0", qat(wr_w, 0), 4);
        check_eq("t3_rows_n", rows.size(), 3);
        check_eq("t3_row0", qat(rows, 0), 0);
        check_eq("t3_row1", qat(rows, 1), 4);
        check_eq("t3_row2", qat(rows, 2), 31);
        check_eq("t3_dv_cnt", dv_cnt, 9);
        check_eq("t3_done_w", done_w, 15);

        // k_len == 0: straight from CLEAR to DRAIN.
        run_tile("t4", 8'd0, 32'h0000_0003, 32'hFFFF_FFFF, 0, -1, 1);
        check_eq("t4_acc_n", acc_w.size(), 0);
        check_eq("t4_wr_n", wr_w.size(), 0);
        check_eq("t4_clr_w", clr_w, 1);
        check_eq("t4_rows_n", rows.size(), 2);
        check_eq("t4_row0", qat(rows, 0), 0);
        check_eq("t4_row1", qat(rows, 1), 1);
        check_eq("t4_done_w", done_w, 4);

        // Empty mask: beats accepted, no enables, no drain.
        run_tile("t5", 8'd2, 32'h0, 32'hFFFF_FFFF, 0, -1, 0);
        check_eq("t5_acc_n", acc_w.size(), 2);
        check_eq("t5_wr_n", wr_w.size(), 0);
        check_eq("t5_dv_cnt", dv_cnt, 0);
        check_eq("t5_done_w", done_w, 7);

        // Start pulsed mid-ACCUM with another config is ignored.
        run_tile("t6", 8'd3, 32'h0000_000F, 32'h0000_0066, 0, 3, 3);
        check_eq("t6_acc_n", acc_w.size(), 3);
        check_eq("t6_acc2", qat(acc_w, 2), 6);
        check_eq("t6_wr_n", wr_w.size(), 3);
        check_eq("t6_rows_n", rows.size(), 4);
        check_eq("t6_row3", qat(rows, 3), 3);
        check_eq("t6_done_w", done_w, 14);

        // Reset in the middle of ACCUM.
        bus.start = 1'b1; bus.k_len = 8'd5; bus.row_mask = 32'hFFFF_FFFF;
        bus.in_valid = 1'b1; bus.drain_ready = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        check_eq("t7_in_ready_pre", bus.in_ready, 1);
        rst_n = 1'b0;
        step();
        check_idle_outputs("t7_rst");
        rst_n = 1'b1;
        step();
        check_eq("t7_done_post1", bus.done, 0);
        check_eq("t7_busy_post1", bus.busy, 0);
        step();
        check_eq("t7_done_post2", bus.done, 0);
        check_eq("t7_wr_post2", bus.wr_en, 0);

        run_tile("t8", 8'd2, 32'h0000_0005, 32'hFFFF_FFFF, 0, -1, 2);
        check_eq("t8_acc_n", acc_w.size(), 2);
        check_eq("t8_wr0", qat(wr_w, 0), 4);
        check_eq("t8_wr1", qat(wr_w, 1), 5);
        check_eq("t8_rows_n", rows.size(), 2);
        check_eq("t8_row0", qat(rows, 0), 0);
        check_eq("t8_row1", qat(rows, 1), 2);
        check_eq("t8_done_w", done_w, 9);

        step();
        check_eq("end_done_pulse", bus.done, 0);
        check_eq("end_busy", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
